// File: rtl/npu_conv_pkg.sv
// Shared types and sizing helpers for the convolution window generator.
package npu_conv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  localparam int K_H_DEF        = 3;
  localparam int K_W_DEF        = 3;
  localparam int DATA_WIDTH_DEF = 9;
  localparam int IMG_W_DEF      = 28;
  localparam int IMG_H_DEF      = 28;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of one flattened K_H x K_W window.
  function automatic int win_w(input int kh, input int kw, input int dw);
    return kh * kw * dw;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of delay: the output is the pixel accepted DEPTH accepts ago.
// Contents carry no reset; they are always overwritten before being used.
module conv_line_buffer #(
  parameter int DEPTH      = 28,
  parameter int DATA_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] sr [DEPTH];

  // Shift one position per accepted pixel.
  always_ff @(posedge clk) begin
    if (en) begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming K_H x K_W sliding-window generator (stride 1, no padding).
// Optional macro CONV_WIN_POS_EN adds out_row/out_col giving the top-left
// output coordinate of the window currently on out_win.
module conv_window_gen
  import npu_conv_pkg::*;
#(
  parameter int K_H        = K_H_DEF,
  parameter int K_W        = K_W_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [K_H*K_W*DATA_WIDTH-1:0]     out_win,
  output logic                              busy,
`ifdef CONV_WIN_POS_EN
  output logic [$clog2(IMG_H)-1:0]          out_row,
  output logic [$clog2(IMG_W)-1:0]          out_col,
`endif
  output logic                              done
);

  localparam int CW    = cnt_w(IMG_W);
  localparam int RW    = cnt_w(IMG_H);
  localparam int WIN_W = win_w(K_H, K_W, DATA_WIDTH);

  state_t                state;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic                  accept;
  logic                  col_last;
  logic                  last_px;
  logic                  produce;

  logic [DATA_WIDTH-1:0] win     [K_H][K_W];
  logic [DATA_WIDTH-1:0] win_nxt [K_H][K_W];
  logic [DATA_WIDTH-1:0] col_in  [K_H];
  logic [DATA_WIDTH-1:0] lb_in   [K_H-1];
  logic [DATA_WIDTH-1:0] lb_out  [K_H-1];
  logic [WIN_W-1:0]      win_flat;

  assign in_ready = (state == STREAM) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign col_last = (col == CW'(IMG_W - 1));
  assign last_px  = col_last && (row == RW'(IMG_H - 1));
  assign produce  = accept && (row >= RW'(K_H - 1)) && (col >= CW'(K_W - 1));

  // Line buffers are chained: each stage delays the column stream by one row.
  for (genvar i = 0; i < K_H - 1; i++) begin : g_lb
    conv_line_buffer #(
      .DEPTH      (IMG_W),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lb (
      .clk  (clk),
      .en   (accept),
      .din  (lb_in[i]),
      .dout (lb_out[i])
    );
  end

  // Route the new pixel and the delayed rows into the column entering the window.
  always_comb begin
    lb_in[0]      = in_data;
    col_in[K_H-1] = in_data;
    for (int i = 1; i < K_H - 1; i++) lb_in[i] = lb_out[i-1];
    for (int i = 0; i < K_H - 1; i++) col_in[K_H-2-i] = lb_out[i];
  end

  // Next window: shift every row left by one column and append the new column.
  always_comb begin
    win_nxt  = win;
    win_flat = '0;
    for (int r = 0; r < K_H; r++) begin
      for (int c = 0; c < K_W - 1; c++) win_nxt[r][c] = win[r][c+1];
      win_nxt[r][K_W-1] = col_in[r];
    end
    for (int r = 0; r < K_H; r++)
      for (int c = 0; c < K_W; c++)
        win_flat[(r*K_W+c)*DATA_WIDTH +: DATA_WIDTH] = win_nxt[r][c];
  end

  // Window registers advance on each accepted pixel; stale columns from the
  // previous row are flushed out before any window of the new row is emitted.
  always_ff @(posedge clk) begin
    if (accept) win <= win_nxt;
  end

  // Frame control: pixel counters, state, busy and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      row   <= '0;
      col   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= STREAM;
            busy  <= 1'b1;
            row   <= '0;
            col   <= '0;
          end
        end
        STREAM: begin
          if (accept) begin
            if (col_last) begin
              col <= '0;
              row <= last_px ? '0 : row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
            if (last_px) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (!out_valid || out_ready) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output register: load a new window, otherwise drop valid once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_win   <= '0;
`ifdef CONV_WIN_POS_EN
      out_row   <= '0;
      out_col   <= '0;
`endif
    end else if (produce) begin
      out_valid <= 1'b1;
      out_win   <= win_flat;
`ifdef CONV_WIN_POS_EN
      out_row   <= row - RW'(K_H - 1);
      out_col   <= col - CW'(K_W - 1);
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen with a 5x4 map and a 3x3 kernel.
module tb_conv_window_gen;

  localparam int KH   = 3;
  localparam int KW   = 3;
  localparam int DW   = 9;
  localparam int IW   = 5;
  localparam int IH   = 4;
  localparam int NPIX = IW * IH;
  localparam int NWC  = IW - KW + 1;
  localparam int NWIN = (IH - KH + 1) * NWC;
  localparam int WW   = KH * KW * DW;
  localparam int GMAX = 4000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic          busy;
  logic          done;
  logic [WW-1:0] out_win;
`ifdef CONV_WIN_POS_EN
  logic [1:0]    out_row;
  logic [2:0]    out_col;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_cons = -1;
  logic prev_vld = 1'b0;
  int acc_edge [NPIX];
  logic [WW-1:0] cap_q [$];
  int rise_q [$];

  always #5 clk = ~clk;

  conv_window_gen #(
    .K_H(KH), .K_W(KW), .DATA_WIDTH(DW), .IMG_W(IW), .IMG_H(IH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_win   (out_win),
    .busy      (busy),
`ifdef CONV_WIN_POS_EN
    .out_row   (out_row),
    .out_col   (out_col),
`endif
    .done      (done)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Passive capture of consumed windows, valid rises and done pulses.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      cap_q.push_back(out_win);
      last_cons = cyc;
    end
    if (rst_n && out_valid && !prev_vld) rise_q.push_back(cyc);
    prev_vld = rst_n && out_valid;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic logic [DW-1:0] pix(input int base, input int idx);
    return DW'((base * 37 + idx) % 512);
  endfunction

  function automatic logic [WW-1:0] exp_win(input int base, input int k);
    logic [WW-1:0] w;
    int r0, c0;
    r0 = k / NWC;
    c0 = k % NWC;
    w = '0;
    for (int i = 0; i < KH; i++)
      for (int j = 0; j < KW; j++)
        w[(i*KW+j)*DW +: DW] = pix(base, (r0 + i) * IW + c0 + j);
    return w;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_out_win"}, out_win, {WW{1'b0}});
  endtask

  task automatic run_frame(input int base, input bit rnd, input int stall,
                           input int restart_at, input int abort_at);
    int idx;
    int guard;
    bit stalled;
    int d0;
    logic [WW-1:0] hold;
    idx = 0;
    guard = 0;
    stalled = 1'b0;
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (idx < NPIX && guard < GMAX) begin
      guard++;
      in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data   = pix(base, idx);
      if (stall > 0 && !stalled && out_valid) begin
        stalled = 1'b1;
        out_ready = 1'b0;
        hold = out_win;
        repeat (stall) begin
          @(negedge clk);
          chk("bp_in_ready", in_ready, 1'b0);
          chk("bp_win_hold", out_win, hold);
          @(posedge clk); #1;
        end
        continue;
      end
      start = (idx == restart_at);
      @(negedge clk);
      if (in_valid && in_ready) begin
        acc_edge[idx] = cyc + 1;
        idx++;
      end
      @(posedge clk); #1;
      if (start) begin
        start = 1'b0;
        chk("busy_on_restart", busy, 1'b1);
      end
      if (idx == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    while (done_cnt == d0 && guard < GMAX) begin
      guard++;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
    end
    chk("frame_timeout", guard < GMAX, 1'b1);
    chk("done_latency", done_cyc, last_cons + 1);
    out_ready = 1'b0;
  endtask

  task automatic check_frame(input int base, input int cb, input string tag);
    chk({tag, "_count"}, cap_q.size() - cb, NWIN);
    for (int k = 0; k < NWIN && cb + k < cap_q.size(); k++)
      chk({tag, "_win"}, cap_q[cb + k], exp_win(base, k));
  endtask

  initial begin
    int cb;
    int rb;
    int d0;
    logic [WW-1:0] w_first;
    logic [WW-1:0] w_last;
    logic [WW-1:0] w_wrap;
    w_first = {9'd12, 9'd11, 9'd10, 9'd7, 9'd6, 9'd5, 9'd2, 9'd1, 9'd0};
    w_last  = {9'd19, 9'd18, 9'd17, 9'd14, 9'd13, 9'd12, 9'd9, 9'd8, 9'd7};
    w_wrap  = {9'd17, 9'd16, 9'd15, 9'd12, 9'd11, 9'd10, 9'd7, 9'd6, 9'd5};

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;

    // full frame, consumer always ready, pixel value = raster index
    cb = cap_q.size();
    rb = rise_q.size();
    run_frame(0, 1'b0, 0, -1, -1);
    check_frame(0, cb, "full");
    chk("first_win", cap_q[cb], w_first);
    chk("wrap_win", cap_q[cb + 3], w_wrap);
    chk("last_win", cap_q[cb + 5], w_last);
    chk("first_latency", rise_q[rb], acc_edge[12]);
    chk("done_count_1", done_cnt, 1);
    chk("idle_busy", busy, 1'b0);

    // backpressure at the first window
    cb = cap_q.size();
    run_frame(1, 1'b0, 10, -1, -1);
    check_frame(1, cb, "bp");

    // start pulsed mid-stream is ignored
    cb = cap_q.size();
    run_frame(2, 1'b0, 0, 7, -1);
    check_frame(2, cb, "restart");
    chk("done_count_3", done_cnt, 3);

    // back-to-back frames
    cb = cap_q.size();
    run_frame(3, 1'b0, 0, -1, -1);
    check_frame(3, cb, "b2b_a");
    cb = cap_q.size();
    run_frame(4, 1'b0, 0, -1, -1);
    check_frame(4, cb, "b2b_b");

    // asynchronous reset after pixel 8, then a clean frame
    d0 = done_cnt;
    cb = cap_q.size();
    run_frame(5, 1'b0, 0, -1, 9);
    chk("abort_no_win", cap_q.size() - cb, 0);
    chk("abort_no_done", done_cnt, d0);
    cb = cap_q.size();
    run_frame(0, 1'b0, 0, -1, -1);
    check_frame(0, cb, "post_rst");
    chk("post_rst_first", cap_q[cb], w_first);

    // random throttling on both sides
    d0 = done_cnt;
    for (int f = 0; f < 200; f++) begin
      cb = cap_q.size();
      run_frame(10 + f, 1'b1, 0, -1, -1);
      check_frame(10 + f, cb, "rand");
    end
    chk("rand_done_count", done_cnt, d0 + 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
